// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-controller FSM states and the
// identifiers of the pipeline stage registers the controller drives.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  // Bit positions of the stage registers within a freeze vector.
  typedef enum logic [2:0] {
    REG_PC      = 3'd0,
    REG_IF_ID   = 3'd1,
    REG_ID_EXE  = 3'd2,
    REG_EXE_MEM = 3'd3,
    REG_MEM_WB  = 3'd4
  } stage_reg_e;

  localparam int NUM_STAGE_REGS = 5;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: resolves memory waits, taken branches and
// data hazards into per-register freeze/flush controls, with perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             freeze_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // The RUN cycle that detects the miss is already frozen, so the wait counter
  // trips one count early to give MEM_TIMEOUT frozen cycles before HALT.
  localparam logic [WAIT_W-1:0] HALT_AT = WAIT_W'(MEM_TIMEOUT - 2);

  ctrl_state_e                state_q, state_d, eff_state;
  logic [WAIT_W-1:0]          wait_cnt_q;
  logic                       timeout_q;
  logic                       halted, mem_block, branch_flush, any_freeze;
  logic [NUM_STAGE_REGS-1:0]  freeze;

  // While reset is held the outputs behave as if the FSM were already in RUN.
  assign eff_state = rst ? state_q : ST_RUN;
  assign halted    = (eff_state == ST_HALT);
  assign mem_block = mem_req & ~mem_ready & ~halted;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_block) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (!mem_block)                 state_d = ST_RUN;
        else if (wait_cnt_q == HALT_AT) state_d = ST_HALT;
      end
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == ST_MEM_WAIT) ? wait_cnt_q + 1'b1 : '0;
      if (state_d == ST_HALT) timeout_q <= 1'b1;
    end
  end

  // A branch seen during a memory wait stays on branch_taken, so it is simply
  // resolved on the first unfrozen cycle.
  always_comb begin
    freeze       = '0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    branch_flush = 1'b0;
    if (mem_block || halted) begin
      freeze = '1;
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
      branch_flush = 1'b1;
    end else if (hazard_stall) begin
      freeze[REG_PC]    = 1'b1;
      freeze[REG_IF_ID] = 1'b1;
      flush_id_exe      = 1'b1;
    end
  end

  assign freeze_pc      = freeze[REG_PC];
  assign freeze_if_id   = freeze[REG_IF_ID];
  assign freeze_id_exe  = freeze[REG_ID_EXE];
  assign freeze_exe_mem = freeze[REG_EXE_MEM];
  assign freeze_mem_wb  = freeze[REG_MEM_WB];
  assign any_freeze     = |freeze;
  assign mem_timeout    = timeout_q;
  assign state          = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_freeze),
    .clr   (perf_clr),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .clr   (perf_clr),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_pipeline_stall_ctrl;

  localparam logic [4:0] FZ_ALL = 5'b11111;
  localparam logic [4:0] FZ_HZ  = 5'b11000;

  typedef struct {
    logic [4:0] fz;
    logic [1:0] fl;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fe;
    logic       to;
    int         row;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hazard_stall = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0, perf_clr = 1'b0;
  logic       freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb;
  logic       flush_if_id, flush_id_exe, mem_timeout;
  logic [1:0] state;
  logic [3:0] stall_cycles, flush_events;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_no   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_stall   (hazard_stall),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .perf_clr       (perf_clr),
    .freeze_pc      (freeze_pc),
    .freeze_if_id   (freeze_if_id),
    .freeze_id_exe  (freeze_id_exe),
    .freeze_exe_mem (freeze_exe_mem),
    .freeze_mem_wb  (freeze_mem_wb),
    .flush_if_id    (flush_if_id),
    .flush_id_exe   (flush_id_exe),
    .mem_timeout    (mem_timeout),
    .state          (state),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  task automatic check(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected while it is applied.
  task automatic cyc(input logic r, hz, br, mr, rdy, clr,
                     input logic [4:0] fz, input logic [1:0] fl,
                     input logic [1:0] st, input logic [3:0] sc,
                     input logic [3:0] fe, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hazard_stall = hz; branch_taken = br;
    mem_req = mr; mem_ready = rdy; perf_clr = clr;
    row_no++;
    e.fz = fz; e.fl = fl; e.st = st; e.sc = sc; e.fe = fe; e.to = to;
    e.row = row_no;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("freeze", mon_e.row, {3'b0, freeze_pc, freeze_if_id, freeze_id_exe,
                                  freeze_exe_mem, freeze_mem_wb}, {3'b0, mon_e.fz});
      check("flush", mon_e.row, {6'b0, flush_if_id, flush_id_exe}, {6'b0, mon_e.fl});
      check("state", mon_e.row, {6'b0, state}, {6'b0, mon_e.st});
      check("stall_cycles", mon_e.row, {4'b0, stall_cycles}, {4'b0, mon_e.sc});
      check("flush_events", mon_e.row, {4'b0, flush_events}, {4'b0, mon_e.fe});
      check("mem_timeout", mon_e.row, {7'b0, mem_timeout}, {7'b0, mon_e.to});
    end
  end

  initial begin
    // Reset, including outputs resolved as RUN while reset is held.
    cyc(0,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);
    cyc(0,1,0,0,0,0, FZ_HZ,  2'b01, 2'd0, 4'd0, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);
    // Single-cycle hazard stall.
    cyc(1,1,0,0,0,0, FZ_HZ,  2'b01, 2'd0, 4'd0, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd1, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd1, 4'd0, 0);
    // Branch beats hazard.
    cyc(1,1,1,0,0,0, 5'b0,   2'b11, 2'd0, 4'd1, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd1, 4'd1, 0);
    // Five-cycle memory wait; ready arrives together with a hazard.
    cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd0, 4'd1, 4'd1, 0);
    for (int k = 2; k <= 5; k++)
      cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'(k), 4'd1, 0);
    cyc(1,1,0,1,1,0, FZ_HZ,  2'b01, 2'd1, 4'd6, 4'd1, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd7, 4'd1, 0);
    // Branch held across a three-cycle memory wait.
    cyc(1,0,1,1,0,0, FZ_ALL, 2'b00, 2'd0, 4'd7, 4'd1, 0);
    cyc(1,0,1,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'd8, 4'd1, 0);
    cyc(1,0,1,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'd9, 4'd1, 0);
    cyc(1,0,1,1,1,0, 5'b0,   2'b11, 2'd1, 4'd10, 4'd1, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd10, 4'd2, 0);
    // Counter clear, saturation, then clear racing a stall.
    cyc(1,0,0,0,0,1, 5'b0,   2'b00, 2'd0, 4'd10, 4'd2, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 18; i++)
      cyc(1,1,0,0,0,0, FZ_HZ, 2'b01, 2'd0, (i > 15) ? 4'd15 : 4'(i), 4'd0, 0);
    cyc(1,1,0,0,0,1, FZ_HZ,  2'b01, 2'd0, 4'd15, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);
    // Memory timeout: eight frozen cycles, then HALT until reset.
    cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd0, 4'd0, 4'd0, 0);
    for (int k = 1; k <= 7; k++)
      cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'(k), 4'd0, 0);
    cyc(1,0,0,0,0,0, FZ_ALL, 2'b00, 2'd2, 4'd8, 4'd0, 1);
    cyc(1,0,1,0,1,0, FZ_ALL, 2'b00, 2'd2, 4'd9, 4'd0, 1);
    cyc(0,0,1,0,0,0, 5'b0,   2'b11, 2'd2, 4'd10, 4'd0, 1);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);
    // Reset in the middle of a memory wait.
    cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd0, 4'd0, 4'd0, 0);
    cyc(1,0,0,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'd1, 4'd0, 0);
    cyc(0,0,0,1,0,0, FZ_ALL, 2'b00, 2'd1, 4'd2, 4'd0, 0);
    cyc(1,0,0,0,0,0, 5'b0,   2'b00, 2'd0, 4'd0, 4'd0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
